alu_cmd_sequencer: RTL and testbench

- Command-side front end for the combinational ALU. Accepts operand/opcode commands from the host link over a valid/ready handshake.
- Drives the ALU operand and opcode inputs from registers and waits a fixed settle time. It then captures the 32-bit ALU result and returns it with an error code over a second valid/ready handshake.
- Screens divide-by-zero and illegal opcodes before issue, so the ALU never computes on bad commands.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: opcode values,
// response error codes, sequencer state encoding and the command screen.
package alu_pkg;

    localparam logic [3:0] OP_MUL  = 4'b0000;
    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_MOD  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LAST = OP_SUB;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_DIV0  = 2'b01,
        ERR_ILLOP = 2'b10
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // An illegal opcode takes priority over a zero divisor, so a bad opcode
    // with Q==0 still reports the opcode problem.
    function automatic err_t screen_cmd(input logic [3:0] op, input logic q_is_zero);
        if (op > OP_LAST) begin
            return ERR_ILLOP;
        end else if (((op == OP_DIV) || (op == OP_MOD)) && q_is_zero) begin
            return ERR_DIV0;
        end else begin
            return ERR_OK;
        end
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Two-entry command FIFO placed ahead of the sequencer FSM.
// Only instantiated when CMD_QUEUE_EN is defined. A push while full is
// accepted when a pop happens in the same cycle.
module alu_cmd_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (do_pop && !do_push) begin
                count <= count - 2'd1;
            end
        end
    end

    // Entry storage needs no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side front end for the combinational ALU. Screens each command,
// drives registered operands to the ALU, waits SETTLE_CYCLES and returns
// the captured result with an error code.
// Build option: define CMD_QUEUE_EN to add a 2-entry command FIFO so the
// host can queue commands while a previous one is still in flight.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int OPW           = 16,
    parameter int RESW          = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OPW-1:0]  cmd_p,
    input  logic [OPW-1:0]  cmd_q,
    input  logic [3:0]      cmd_op,
    output logic [OPW-1:0]  alu_p,
    output logic [OPW-1:0]  alu_q,
    output logic [3:0]      alu_op,
    input  logic [RESW-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [RESW-1:0] rsp_data,
    output logic [1:0]      rsp_err,
    output logic            busy
);

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     count;
    logic           take;
    logic [OPW-1:0] in_p;
    logic [OPW-1:0] in_q;
    logic [3:0]     in_op;
    err_t           in_err;

`ifdef CMD_QUEUE_EN
    localparam int FW = 2 * OPW + 4;

    logic          fifo_empty;
    logic          fifo_full;
    logic [FW-1:0] fifo_head;

    assign cmd_ready = !fifo_full;
    assign take      = (state == ST_IDLE) && !fifo_empty;
    assign {in_op, in_q, in_p} = fifo_head;

    alu_cmd_fifo #(
        .W(FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && !fifo_full),
        .push_data ({cmd_op, cmd_q, cmd_p}),
        .pop       (take),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
`else
    assign cmd_ready = (state == ST_IDLE);
    assign take      = cmd_valid && (state == ST_IDLE);
    assign in_p      = cmd_p;
    assign in_q      = cmd_q;
    assign in_op     = cmd_op;
`endif

    assign in_err    = screen_cmd(in_op, (in_q == '0));
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: bad commands skip the settle wait entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    state_nxt = (in_err == ERR_OK) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (count == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: ALU operand issue, settle countdown and response capture.
    // The response registers are only written on the way into RESP, so
    // they stay stable while the consumer back-pressures.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_p    <= '0;
            alu_q    <= '0;
            alu_op   <= 4'd0;
            count    <= 4'd0;
            rsp_data <= '0;
            rsp_err  <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        if (in_err == ERR_OK) begin
                            alu_p  <= in_p;
                            alu_q  <= in_q;
                            alu_op <= in_op;
                            count  <= 4'(SETTLE_CYCLES - 1);
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= in_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        rsp_data <= alu_result;
                        rsp_err  <= ERR_OK;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer (default build, no command
// queue). Includes a behavioural ALU driven by the sequencer's alu_* outputs.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_p;
    logic [15:0] cmd_q;
    logic [3:0]  cmd_op;
    logic [15:0] alu_p;
    logic [15:0] alu_q;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;

    typedef struct {
        logic [15:0] p;
        logic [15:0] q;
        logic [3:0]  op;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
    } rsp_t;

    vec_t        vecs[12];
    int          acc[12];
    rsp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] mp;
    logic [15:0] mq;
    logic [3:0]  mop;

    alu_cmd_sequencer #(
        .OPW(16),
        .RESW(32),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_p      (cmd_p),
        .cmd_q      (cmd_q),
        .cmd_op     (cmd_op),
        .alu_p      (alu_p),
        .alu_q      (alu_q),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: zero-extended 32-bit arithmetic on the operands.
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'd0: alu_result = {16'd0, alu_p} * {16'd0, alu_q};
            4'd1: alu_result = (alu_q == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_p} / {16'd0, alu_q};
            4'd2: alu_result = (alu_q == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_p} % {16'd0, alu_q};
            4'd3: alu_result = {16'd0, alu_p} + {16'd0, alu_q};
            4'd4: alu_result = {16'd0, alu_p} - {16'd0, alu_q};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Pops the oldest expected response and compares it against the DUT.
    task automatic checkOutput();
        rsp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected_rsp actual=0x%0h expected=none", rsp_data);
        end else begin
            e = sb.pop_front();
            compareValue("rsp_data", rsp_data, e.data);
            compareValue("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
        end
    endtask

    // Offers one command, records its acceptance edge, checks issued ALU
    // operands and accept-to-response latency, then consumes the response.
    task automatic applyStimulus(input vec_t v, output int acc_edge);
        int n;
        int k;
        acc_edge = -1;
        @(negedge clk);
        cmd_p     = v.p;
        cmd_q     = v.q;
        cmd_op    = v.op;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=not_ready expected=ready");
            cmd_valid = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        sb.push_back('{v.data, v.err});
        if (v.err == 2'b00) begin
            mp  = v.p;
            mq  = v.q;
            mop = v.op;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        compareValue("alu_p", {16'd0, alu_p}, {16'd0, mp});
        compareValue("alu_q", {16'd0, alu_q}, {16'd0, mq});
        compareValue("alu_op", {28'd0, alu_op}, {28'd0, mop});
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        compareValue("latency", 32'(k), 32'(v.lat));
        if (rsp_valid) begin
            checkOutput();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int hits;
        vecs[0]  = '{16'd300,   16'd200,   4'h0, 32'd60000,      2'b00, 2};
        vecs[1]  = '{16'd100,   16'd7,     4'h1, 32'd14,         2'b00, 2};
        vecs[2]  = '{16'd100,   16'd7,     4'h2, 32'd2,          2'b00, 2};
        vecs[3]  = '{16'd5,     16'd0,     4'h1, 32'd0,          2'b01, 0};
        vecs[4]  = '{16'd61,    16'd59,    4'hA, 32'd0,          2'b10, 0};
        vecs[5]  = '{16'd61,    16'd59,    4'h4, 32'd2,          2'b00, 2};
        vecs[6]  = '{16'hFFFF,  16'hFFFF,  4'h0, 32'hFFFE_0001,  2'b00, 2};
        vecs[7]  = '{16'd3,     16'd5,     4'h4, 32'hFFFF_FFFE,  2'b00, 2};
        vecs[8]  = '{16'd9,     16'd0,     4'h2, 32'd0,          2'b01, 0};
        vecs[9]  = '{16'd1234,  16'd0,     4'h3, 32'd1234,       2'b00, 2};
        vecs[10] = '{16'd1,     16'd1,     4'hF, 32'd0,          2'b10, 0};
        vecs[11] = '{16'd0,     16'd0,     4'h5, 32'd0,          2'b10, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_p     = 16'd0;
        cmd_q     = 16'd0;
        cmd_op    = 4'd0;
        rsp_ready = 1'b1;
        mp        = 16'd0;
        mq        = 16'd0;
        mop       = 4'd0;

        repeat (2) @(negedge clk);
        compareValue("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        compareValue("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        compareValue("rst_rsp_data", rsp_data, 32'd0);
        compareValue("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        compareValue("rst_alu_p", {16'd0, alu_p}, 32'd0);
        compareValue("rst_alu_q", {16'd0, alu_q}, 32'd0);
        compareValue("rst_alu_op", {28'd0, alu_op}, 32'd0);
        compareValue("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], acc[i]);
        end
        compareValue("div_mod_spacing", 32'(acc[2] - acc[1]), 32'd4);
        compareValue("err_spacing", 32'(acc[4] - acc[3]), 32'd2);

        // Backpressure: response held for 5 cycles, a second command offered
        // meanwhile must not be taken.
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_p     = 16'd20;
        cmd_q     = 16'd3;
        cmd_op    = 4'h3;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        compareValue("bp_accept", {31'd0, cmd_ready}, 32'd1);
        sb.push_back('{32'd23, 2'b00});
        mp  = 16'd20;
        mq  = 16'd3;
        mop = 4'h3;
        @(negedge clk);
        cmd_p  = 16'd7;
        cmd_q  = 16'd7;
        cmd_op = 4'h0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            compareValue("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            compareValue("bp_rsp_data", rsp_data, 32'd23);
            compareValue("bp_rsp_err", {30'd0, rsp_err}, 32'd0);
            compareValue("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            compareValue("bp_busy", {31'd0, busy}, 32'd1);
            compareValue("bp_alu_p", {16'd0, alu_p}, {16'd0, mp});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        checkOutput();
        @(negedge clk);
        compareValue("bp_done_busy", {31'd0, busy}, 32'd0);
        compareValue("bp_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        compareValue("bp_done_alu_op", {28'd0, alu_op}, {28'd0, mop});
        compareValue("bp_done_alu_q", {16'd0, alu_q}, {16'd0, mq});

        // Reset one cycle after accept drops the command with no response.
        cmd_p     = 16'd50;
        cmd_q     = 16'd2;
        cmd_op    = 4'h0;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        compareValue("mid_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mp  = 16'd0;
        mq  = 16'd0;
        mop = 4'd0;
        compareValue("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        compareValue("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        compareValue("mrst_busy", {31'd0, busy}, 32'd0);
        compareValue("mrst_alu_p", {16'd0, alu_p}, 32'd0);
        compareValue("mrst_alu_q", {16'd0, alu_q}, 32'd0);
        compareValue("mrst_alu_op", {28'd0, alu_op}, 32'd0);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        compareValue("mrst_no_rsp", 32'(hits), 32'd0);

        compareValue("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
